// File: rtl/jtag_pkg.sv
// Shared types and constants for the hardware JTAG shift engine.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        RESP = 2'd3
    } jtag_state_t;

    localparam int   JTAG_MAX_LEN  = 32;
    localparam int   JTAG_LEN_W    = 6;
    localparam logic JTAG_TMS_IDLE = 1'b1;

    // Lengths beyond the vector width shift the full vector.
    function automatic logic [JTAG_LEN_W-1:0] clamp_len(input logic [JTAG_LEN_W-1:0] len);
        return (len > JTAG_LEN_W'(JTAG_MAX_LEN)) ? JTAG_LEN_W'(JTAG_MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/jtag_shift_engine_if.sv
// Command/response handshake bundle between the GPIO-side master and the shift engine.
interface jtag_shift_engine_if;
    import jtag_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [JTAG_LEN_W-1:0]   cmd_len;
    logic [JTAG_MAX_LEN-1:0] cmd_tms;
    logic [JTAG_MAX_LEN-1:0] cmd_tdi;
    logic                    cmd_trst;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [JTAG_MAX_LEN-1:0] rsp_tdo;

    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_trst, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_trst, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// Half-period timer: strobes phase_end on the last clk cycle of every tck phase while running.
module jtag_tck_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic phase_end
);

    localparam logic [7:0] LAST_CNT = 8'(HALF_PERIOD - 1);

    logic [7:0] cnt_reg;
    logic       running_reg;

    assign phase_end = running_reg && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            cnt_reg     <= '0;
            running_reg <= 1'b1;
        end else if (stop) begin
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (phase_end) begin
            cnt_reg <= '0;
        end else if (running_reg) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: shifts up to 32 TMS/TDI bit pairs toward the TAP, captures TDO, and
// returns the captured vector; also issues TRST pulses.
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int MAX_LEN     = JTAG_MAX_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    jtag_shift_engine_if.slave  bus,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    output logic                trst_n,
    input  logic                tdo
);

    localparam int IDX_W = $clog2(JTAG_MAX_LEN);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOW  = LOW;
    localparam logic [1:0] ST_HIGH = HIGH;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]              state_reg, state_next;
    logic                    ready_en_reg;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [JTAG_LEN_W-1:0]   len_reg, len_next;
    logic [JTAG_MAX_LEN-1:0] tms_vec_reg, tms_vec_next;
    logic [JTAG_MAX_LEN-1:0] tdi_vec_reg, tdi_vec_next;
    logic                    trst_mode_reg, trst_mode_next;
    logic                    done_reg, done_next;
    logic                    tck_reg, tck_next;
    logic                    tms_reg, tms_next;
    logic                    tdi_reg, tdi_next;
    logic                    trst_n_reg, trst_n_next;
    logic [MAX_LEN-1:0]      tdo_vec_reg;
    logic [MAX_LEN-1:0]      cap_sel;

    logic cmd_ready_int;
    logic accept;
    logic last_bit;
    logic capture_en;
    logic gen_start, gen_stop, phase_end;

    jtag_tck_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (gen_start),
        .stop     (gen_stop),
        .phase_end(phase_end)
    );

    // ready_en_reg keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready_int = ready_en_reg && (state_reg == ST_IDLE);
    assign accept        = bus.cmd_valid && cmd_ready_int;
    assign last_bit      = ({1'b0, idx_reg} == (len_reg - 6'd1));
    assign capture_en    = (state_reg == ST_HIGH) && phase_end && !trst_mode_reg;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        len_next       = len_reg;
        tms_vec_next   = tms_vec_reg;
        tdi_vec_next   = tdi_vec_reg;
        trst_mode_next = trst_mode_reg;
        done_next      = done_reg;
        tck_next       = tck_reg;
        tms_next       = tms_reg;
        tdi_next       = tdi_reg;
        trst_n_next    = trst_n_reg | ~ready_en_reg;
        gen_start      = 1'b0;
        gen_stop       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    tms_vec_next   = bus.cmd_tms;
                    tdi_vec_next   = bus.cmd_tdi;
                    len_next       = clamp_len(bus.cmd_len);
                    idx_next       = '0;
                    trst_mode_next = bus.cmd_trst;
                    state_next     = ST_LOW;
                    if (bus.cmd_trst) begin
                        trst_n_next = 1'b0;
                        gen_start   = 1'b1;
                    end else if (bus.cmd_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        tms_next  = bus.cmd_tms[0];
                        tdi_next  = bus.cmd_tdi[0];
                        gen_start = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                // done_reg marks the single settling cycle between the work and RESP.
                if (done_reg) begin
                    done_next  = 1'b0;
                    state_next = ST_RESP;
                end else if (phase_end) begin
                    tck_next   = !trst_mode_reg;
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    tck_next   = 1'b0;
                    state_next = ST_LOW;
                    if (trst_mode_reg || last_bit) begin
                        trst_n_next = 1'b1;
                        gen_stop    = 1'b1;
                        done_next   = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        tms_next = tms_vec_reg[idx_next];
                        tdi_next = tdi_vec_reg[idx_next];
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cap_sel
        assign cap_sel[gi] = capture_en && (idx_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ready_en_reg  <= 1'b0;
            idx_reg       <= '0;
            len_reg       <= '0;
            tms_vec_reg   <= '0;
            tdi_vec_reg   <= '0;
            trst_mode_reg <= 1'b0;
            done_reg      <= 1'b0;
            tck_reg       <= 1'b0;
            tms_reg       <= JTAG_TMS_IDLE;
            tdi_reg       <= 1'b0;
            trst_n_reg    <= 1'b0;
            tdo_vec_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ready_en_reg  <= 1'b1;
            idx_reg       <= idx_next;
            len_reg       <= len_next;
            tms_vec_reg   <= tms_vec_next;
            tdi_vec_reg   <= tdi_vec_next;
            trst_mode_reg <= trst_mode_next;
            done_reg      <= done_next;
            tck_reg       <= tck_next;
            tms_reg       <= tms_next;
            tdi_reg       <= tdi_next;
            trst_n_reg    <= trst_n_next;
            if (accept) begin
                tdo_vec_reg <= '0;
            end else begin
                tdo_vec_reg <= (tdo_vec_reg & ~cap_sel) | (cap_sel & {MAX_LEN{tdo}});
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_int;
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.rsp_tdo   = tdo_vec_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign tck           = tck_reg;
    assign tms           = tms_reg;
    assign tdi           = tdi_reg;
    assign trst_n        = trst_n_reg;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench: two engines (half-period 2 and 3), a behavioural TAP for IR access
// and a loopback TDO source for full-length shifts.
module tb_jtag_shift_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtag_shift_engine_if bus2 ();
    jtag_shift_engine_if bus3 ();

    logic busy2, tck2, tms2, tdi2, trst_n2, tdo2;
    logic busy3, tck3, tms3, tdi3, trst_n3;

    jtag_shift_engine #(.HALF_PERIOD(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2),
        .tck(tck2), .tms(tms2), .tdi(tdi2), .trst_n(trst_n2), .tdo(tdo2)
    );

    jtag_shift_engine #(.HALF_PERIOD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3),
        .tck(tck3), .tms(tms3), .tdi(tdi3), .trst_n(trst_n3), .tdo(1'b0)
    );

    localparam int T_TLR = 0,  T_RTI = 1,  T_SELDR = 2, T_CAPDR = 3;
    localparam int T_SHDR = 4, T_EX1DR = 5, T_PDR = 6,  T_EX2DR = 7;
    localparam int T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10, T_SHIR = 11;
    localparam int T_EX1IR = 12, T_PIR = 13, T_EX2IR = 14, T_UPIR = 15;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PDR;
            T_PDR:   return m ? T_EX2DR : T_PDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PIR;
            T_PIR:   return m ? T_EX2IR : T_PIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    // Behavioural TAP: IR captures 4'b0001, TDO changes on falling tck.
    int         tap_state = T_TLR;
    logic [3:0] ir_sr = 4'h0;
    logic       tap_tdo = 1'b0;
    logic       loop_prev = 1'b0, loop_tdo = 1'b0;
    logic       use_tap = 1'b1;

    always @(posedge tck2 or negedge trst_n2) begin
        if (!trst_n2) begin
            tap_state <= T_TLR;
        end else begin
            if (tap_state == T_CAPIR) ir_sr <= 4'b0001;
            else if (tap_state == T_SHIR) ir_sr <= {tdi2, ir_sr[3:1]};
            tap_state <= tap_next(tap_state, tms2);
        end
    end

    always @(negedge tck2) begin
        if (tap_state == T_SHIR) tap_tdo <= ir_sr[0];
    end

    // Loopback source: during bit i the TDO line carries the TDI of bit i-1.
    always @(posedge tck2) begin
        loop_tdo  <= loop_prev;
        loop_prev <= tdi2;
    end

    assign tdo2 = use_tap ? tap_tdo : loop_tdo;

    int tck2_pulses = 0, tck2_hi_cyc = 0, tck3_pulses = 0, trst3_low = 0;
    always @(posedge tck2) tck2_pulses <= tck2_pulses + 1;
    always @(posedge tck3) tck3_pulses <= tck3_pulses + 1;
    always @(posedge clk) if (tck2) tck2_hi_cyc <= tck2_hi_cyc + 1;
    always @(posedge clk) if (!trst_n3) trst3_low <= trst3_low + 1;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit sel, input logic [5:0] len, input logic [31:0] tmsv,
                         input logic [31:0] tdiv, input logic trst);
        int w;
        w = 0;
        @(negedge clk);
        while (((sel ? bus3.cmd_ready : bus2.cmd_ready) !== 1'b1) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_before_issue", 32'(sel ? bus3.cmd_ready : bus2.cmd_ready), 32'd1);
        if (sel) begin
            bus3.cmd_len = len; bus3.cmd_tms = tmsv; bus3.cmd_tdi = tdiv;
            bus3.cmd_trst = trst; bus3.cmd_valid = 1'b1;
        end else begin
            bus2.cmd_len = len; bus2.cmd_tms = tmsv; bus2.cmd_tdi = tdiv;
            bus2.cmd_trst = trst; bus2.cmd_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus2.cmd_valid = 1'b0;
        bus3.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (((sel ? bus3.rsp_valid : bus2.rsp_valid) !== 1'b1) && lat < 400);
    endtask

    task automatic consume(input bit sel);
        @(negedge clk);
        if (sel) bus3.rsp_ready = 1'b1; else bus2.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.rsp_ready = 1'b0;
        bus3.rsp_ready = 1'b0;
        check("rsp_valid_after_consume", 32'(sel ? bus3.rsp_valid : bus2.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat, p0, h0, t0, seen, w;
        logic [31:0] loop_tdi;
        logic [31:0] r;

        bus2.cmd_valid = 1'b0; bus2.cmd_len = '0; bus2.cmd_tms = '0; bus2.cmd_tdi = '0;
        bus2.cmd_trst = 1'b0; bus2.rsp_ready = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_len = '0; bus3.cmd_tms = '0; bus3.cmd_tdi = '0;
        bus3.cmd_trst = 1'b0; bus3.rsp_ready = 1'b0;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_tck", 32'(tck2), 32'd0);
        check("rst_tms", 32'(tms2), 32'd1);
        check("rst_tdi", 32'(tdi2), 32'd0);
        check("rst_trst_n", 32'(trst_n2), 32'd0);
        check("rst_cmd_ready", 32'(bus2.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_rsp_tdo", bus2.rsp_tdo, 32'd0);
        check("rst_tms3_tdi3", {30'd0, tms3, tdi3}, 32'd2);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_trst_n", 32'(trst_n2), 32'd1);
        check("post_rst_cmd_ready", 32'(bus2.cmd_ready), 32'd1);
        check("post_rst_trst_n3", 32'(trst_n3), 32'd1);

        // Navigate TLR -> Shift-IR
        issue(0, 6'd5, 32'h06, 32'h0, 1'b0);
        wait_rsp(0, lat);
        check("nav_latency", 32'(lat), 32'd21);
        consume(0);
        check("nav_tap_state", 32'(tap_state), 32'(T_SHIR));

        // IR shift: capture value 0001 comes back, TAP ends in Exit1-IR
        issue(0, 6'd4, 32'h8, 32'hA, 1'b0);
        wait_rsp(0, lat);
        check("ir_latency", 32'(lat), 32'd17);
        check("ir_rsp_tdo", bus2.rsp_tdo, 32'h1);
        check("ir_tap_state", 32'(tap_state), 32'(T_EX1IR));
        check("ir_loaded", 32'(ir_sr), 32'hA);

        // Backpressure: response held, no new command accepted
        repeat (10) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus2.rsp_valid), 32'd1);
            check("bp_rsp_tdo", bus2.rsp_tdo, 32'h1);
            check("bp_cmd_ready", 32'(bus2.cmd_ready), 32'd0);
        end
        consume(0);

        // Zero length: response next cycle, no tck activity
        p0 = tck2_pulses;
        issue(0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_rsp(0, lat);
        check("zero_latency", 32'(lat), 32'd1);
        check("zero_rsp_tdo", bus2.rsp_tdo, 32'd0);
        check("zero_tck_pulses", 32'(tck2_pulses - p0), 32'd0);
        consume(0);

        // Five TMS=1 bits drive the TAP to Test-Logic-Reset
        p0 = tck2_pulses;
        h0 = tck2_hi_cyc;
        issue(0, 6'd5, 32'h1F, 32'h0, 1'b0);
        wait_rsp(0, lat);
        check("tlr_latency", 32'(lat), 32'd21);
        check("tlr_tck_pulses", 32'(tck2_pulses - p0), 32'd5);
        check("tlr_tck_high_cycles", 32'(tck2_hi_cyc - h0), 32'd10);
        check("tlr_tap_state", 32'(tap_state), 32'(T_TLR));
        check("tlr_tck_low_in_resp", 32'(tck2), 32'd0);
        consume(0);

        // Full-length loopback
        use_tap = 1'b0;
        loop_tdi = 32'hC3A5_5A3C;
        issue(0, 6'd32, 32'h0, loop_tdi, 1'b0);
        wait_rsp(0, lat);
        check("loop_latency", 32'(lat), 32'd129);
        r = bus2.rsp_tdo;
        check("loop_rsp_tdo", {1'b0, r[31:1]}, {1'b0, loop_tdi[30:0]});
        consume(0);

        // TRST pulse on the half-period-3 engine; cmd_len is ignored
        p0 = tck3_pulses;
        t0 = trst3_low;
        issue(1, 6'd5, 32'h1F, 32'h0, 1'b1);
        check("trst_busy", 32'(busy3), 32'd1);
        wait_rsp(1, lat);
        check("trst_latency", 32'(lat), 32'd7);
        check("trst_low_cycles", 32'(trst3_low - t0), 32'd6);
        check("trst_no_tck", 32'(tck3_pulses - p0), 32'd0);
        check("trst_rsp_tdo", bus3.rsp_tdo, 32'd0);
        consume(1);

        // cmd_len 45 is clamped to 32
        p0 = tck3_pulses;
        issue(1, 6'd45, 32'h0, 32'h0, 1'b0);
        wait_rsp(1, lat);
        check("clamp_latency", 32'(lat), 32'd193);
        check("clamp_tck_pulses", 32'(tck3_pulses - p0), 32'd32);
        consume(1);

        // Reset during bit 10 of a 32-bit shift
        p0 = tck2_pulses;
        issue(0, 6'd32, 32'h0, 32'hFFFF_FFFF, 1'b0);
        w = 0;
        while ((tck2_pulses - p0) < 11 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_bit10", 32'(tck2_pulses - p0), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tck", 32'(tck2), 32'd0);
        check("abort_tms_tdi", {30'd0, tms2, tdi2}, 32'd2);
        check("abort_trst_n", 32'(trst_n2), 32'd0);
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus2.rsp_valid === 1'b1) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        check("abort_cmd_ready", 32'(bus2.cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_shift_engine.md
# jtag_shift_engine

Hardware JTAG master that replaces software bit-banging of the GPIO bus feeding `tap_core`. It accepts shift commands of up to 32 TMS/TDI bit pairs over a valid/ready interface and generates `tck`/`tms`/`tdi`/`trst_n` with a programmable half-period. It captures `tdo` for every bit and returns the captured vector over a valid/ready response interface. It sits between the PS GPIO block and `tap_core`, directly upstream of the TAP.

## Interface
Parameters:
- `HALF_PERIOD`, default 2: clk cycles per tck phase, legal range 1..255.
- `MAX_LEN`, default 32: bits per command, fixed at 32.

Ports:
- `clk`  in  1  system clock; `tck` is derived from it.
- `rst_n`  in  1  reset, asynchronous assert; **one clock; reset is asynchronous and active-low**.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_len`  in  6  number of bits to shift. 1..32 is legal; 0 means no shift.
- `cmd_tms`  in  32  TMS bit per shifted bit, LSB first.
- `cmd_tdi`  in  32  TDI bit per shifted bit, LSB first.
- `cmd_trst`  in  1  perform a TAP reset pulse instead of a shift.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_tdo`  out  32  captured TDO, LSB first; bits at and above `cmd_len` are 0.
- `busy`  out  1  high while in any state other than IDLE.
- `tck`, `tms`, `tdi`, `trst_n`  out  1 each  JTAG pins toward `tap_core`.
- `tdo`  in  1  from `tap_core`.

## Operation
- The FSM has four states: IDLE, LOW, HIGH, RESP.
- **Accept.** A command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` equals `(state==IDLE)`. On accept, all `cmd_*` fields are latched and the bit index is cleared to 0.
- **Dispatch on accept:**
  - `cmd_trst=1` (takes priority over `cmd_len`): `trst_n` goes 0 for `2*HALF_PERIOD` cycles, then the FSM goes to RESP with `rsp_tdo=0`. `tck` stays 0.
  - `cmd_len==0`: go to RESP on the next cycle with `rsp_tdo=0`.
  - Otherwise go to LOW.
- **LOW.**
  - On entry, `tms`/`tdi` take bit[idx] and `tck=0`.
  - After `HALF_PERIOD` cycles, go to HIGH.
- **HIGH.**
  - `tck=1` for `HALF_PERIOD` cycles.
  - `tdo` is sampled into `rsp_tdo[idx]` on the last clk cycle of HIGH. `tap_core` updates `tdo` on falling `tck`, so it is stable during HIGH.
  - At the end of HIGH: if `idx==cmd_len-1`, go to RESP with `tck=0`; otherwise increment `idx` and go to LOW.
- **RESP.**
  - `rsp_valid=1`. `rsp_tdo` is held stable.
  - On `rsp_ready`, go to IDLE.
  - No new command is accepted until the response is consumed.
- **Idle pin levels.** `tms`/`tdi` hold their last driven values. `tck` is 0.
- **Clocking.** `tck` is a registered output of `clk`, so `tdo` is treated as synchronous to `clk`. No synchronizer is used.

## Timing
- **Reset values:**
  - `cmd_ready=0` while `rst_n=0`; 1 from the first clk edge after deassert.
  - `rsp_valid=0`, `rsp_tdo=0`, `busy=0`, `tck=0`, `tms=1`, `tdi=0`.
  - `trst_n=0` while `rst_n=0`; `trst_n=1` from the first clk edge after deassert.
- **Shift latency.** Accept edge to `rsp_valid` high is `2*HALF_PERIOD*cmd_len + 1` cycles.
- **Bit pin timing.** Each bit holds `tms`/`tdi` constant across a full tck period. Values change only when `tck` goes 0.
- **TRST latency.** Accept edge to `rsp_valid` is `2*HALF_PERIOD + 1` cycles.
- **Zero-length latency.** `cmd_len==0`: `rsp_valid` rises 1 cycle after accept.
- **Back-to-back.** With `rsp_ready` held at 1, RESP lasts 1 cycle and IDLE lasts at least 1 cycle. Back-to-back commands therefore have at least a 2-cycle gap with `tck=0`.
- **Reset mid-operation.** All outputs return to reset values asynchronously. The in-flight command is discarded and no response is produced.
- **`cmd_len` above 32.** Values 33..63 are clamped to 32.

## Structure
- Package `jtag_pkg`:
  - `typedef enum` `jtag_state_t` with values IDLE, LOW, HIGH, RESP.
  - `JTAG_MAX_LEN=32`, `JTAG_LEN_W=6`.
  - `JTAG_TMS_IDLE=1'b1`.
- Sub-module `jtag_tck_gen`: half-period counter with `start` and `stop` inputs and a `phase_end` strobe output. The FSM advances only on `phase_end`.
- Top-level integration: `gpio_out` writes the command registers and `gpio_in` reads the response. That wiring is outside this block.

## Test plan
- **Reset:** hold `rst_n=0` for 5 cycles → `tck=0`, `tms=1`, `trst_n=0`, `cmd_ready=0`. One edge after release → `trst_n=1`, `cmd_ready=1`.
- **Five-bit TMS reset:** `HALF_PERIOD=2`, `cmd_len=5`, `cmd_tms=0x1F`, `cmd_tdi=0` → exactly 5 tck pulses, 4 cycles per period. `tap_core` `tap_state` reaches Test-Logic-Reset. `rsp_valid` arrives 21 cycles after accept.
- **IR shift:** navigate to Shift-IR, then shift `cmd_len=4`, `cmd_tdi=0xA`, `tms=0x8` → `rsp_tdo` equals the IR capture value (bits[1:0]=01), and the TAP exits to Exit1-IR.
- **Full-length loopback:** `cmd_len=32`, `tdo` model returns the `tdi` from the previous period → `rsp_tdo[31:1]=cmd_tdi[30:0]`.
- **Response backpressure and zero length:** hold `rsp_ready=0` for 10 cycles → `rsp_valid` and `rsp_tdo` stable, `cmd_ready=0`. Then `cmd_len=0` → response 1 cycle after accept, `rsp_tdo=0`, no tck edges.
- **TRST and reset abort:**
  - `cmd_trst=1`, `HALF_PERIOD=3` → `trst_n` low for exactly 6 cycles, response after 7 cycles.
  - Separately, pulse `rst_n` low at bit 10 of a 32-bit shift → `tck=0` immediately and no `rsp_valid`.
